// File: rtl/ad1_adc_responder.sv
// ad1_adc_responder: device-side model of the dual-channel AD1 serial ADC link.
// Answers ADC_csn/ADC_sclk from a capture master with two serial data lines.
// Each frame is LEAD_ZEROS zeros followed by a DATA_W-bit sample, MSB first,
// with bits changing on the SCLK falling edge. Samples come from a
// valid/ready stream that is accepted only at frame start.
// Optional feature: define AD1_RAMP_EN to add ramp_sel and an internal ramp
// pattern source (ch0 = ramp, ch1 = ~ramp).
module ad1_adc_responder #(
    parameter int DATA_W      = 12,
    parameter int LEAD_ZEROS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data0,
    input  logic [DATA_W-1:0] s_data1,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              ADC_csn,
    input  logic              ADC_sclk,
    output logic              ADC_sdata0,
    output logic              ADC_sdata1,
    output logic              frame_done,
    output logic              underrun,
    output logic              aborted
`ifdef AD1_RAMP_EN
    ,
    input  logic              ramp_sel
`endif
);

    localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic                   csn_hist;
    logic                   sclk_hist;
    logic                   csn_s;
    logic                   sclk_s;
    logic                   csn_fall;
    logic                   csn_rise;
    logic                   sclk_fall;

    logic [FRAME_BITS-1:0]  sh0;
    logic [FRAME_BITS-1:0]  sh1;
    logic [DATA_W-1:0]      held0;
    logic [DATA_W-1:0]      held1;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   last_bit;

    logic                   do_load;
    logic                   do_shift;
    logic                   do_finish;
    logic                   do_abort;
    logic                   use_ramp;
    logic                   take_sample;
    logic                   do_underrun;
    logic [DATA_W-1:0]      load0;
    logic [DATA_W-1:0]      load1;
    logic [FRAME_BITS-1:0]  load_word0;
    logic [FRAME_BITS-1:0]  load_word1;

    // Synchroniser chains plus one history flop for edge detection. These are
    // deliberately left out of reset: a reset while csn is held low must not
    // look like a fresh csn falling edge once reset is released.
    always_ff @(posedge clk) begin
        csn_sync  <= {csn_sync[SYNC_STAGES-2:0], ADC_csn};
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ADC_sclk};
        csn_hist  <= csn_sync[SYNC_STAGES-1];
        sclk_hist <= sclk_sync[SYNC_STAGES-1];
    end

    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csn_fall  = csn_hist & ~csn_s;
    assign csn_rise  = ~csn_hist & csn_s;
    // sclk activity only matters while the frame select is low
    assign sclk_fall = sclk_hist & ~sclk_s & ~csn_s;
    assign last_bit  = (bit_cnt == CNT_W'(FRAME_BITS - 1));

`ifdef AD1_RAMP_EN
    logic [DATA_W-1:0] ramp;

    // Free-running pattern counter, advanced on every frame load
    always_ff @(posedge clk) begin
        if (rst) begin
            ramp <= '0;
        end else if (do_load) begin
            ramp <= ramp + 1'b1;
        end
    end

    assign use_ramp = ramp_sel;
    assign load0    = ramp_sel ? ramp  : (s_valid ? s_data0 : held0);
    assign load1    = ramp_sel ? ~ramp : (s_valid ? s_data1 : held1);
`else
    assign use_ramp = 1'b0;
    assign load0    = s_valid ? s_data0 : held0;
    assign load1    = s_valid ? s_data1 : held1;
`endif

    assign load_word0 = {{LEAD_ZEROS{1'b0}}, load0};
    assign load_word1 = {{LEAD_ZEROS{1'b0}}, load1};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; a csn rise always wins over a same-cycle sclk fall
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (csn_fall) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (csn_rise) begin
                    state_nxt = IDLE;
                end else if (sclk_fall && last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (csn_rise) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output decode: per-cycle datapath actions
    always_comb begin
        do_load     = 1'b0;
        do_shift    = 1'b0;
        do_finish   = 1'b0;
        do_abort    = 1'b0;
        case (state)
            IDLE: begin
                do_load = csn_fall;
            end
            SHIFT: begin
                do_abort  = csn_rise;
                do_shift  = ~csn_rise & sclk_fall & ~last_bit;
                do_finish = ~csn_rise & sclk_fall & last_bit;
            end
            default: ;
        endcase
        take_sample = do_load & s_valid & ~use_ramp;
        do_underrun = do_load & ~s_valid & ~use_ramp;
    end

    // Shift registers, held sample, bit counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            held0      <= '0;
            held1      <= '0;
            bit_cnt    <= '0;
            s_ready    <= 1'b0;
            frame_done <= 1'b0;
            ADC_sdata0 <= 1'b0;
            ADC_sdata1 <= 1'b0;
            underrun   <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            s_ready    <= take_sample;
            frame_done <= do_finish;
            if (take_sample) begin
                held0 <= s_data0;
                held1 <= s_data1;
            end
            if (do_underrun) begin
                underrun <= 1'b1;
            end
            if (do_abort) begin
                aborted <= 1'b1;
            end
            if (do_load) begin
                sh0        <= load_word0;
                sh1        <= load_word1;
                bit_cnt    <= '0;
                ADC_sdata0 <= load_word0[FRAME_BITS-1];
                ADC_sdata1 <= load_word1[FRAME_BITS-1];
            end else if (do_shift) begin
                sh0        <= {sh0[FRAME_BITS-2:0], 1'b0};
                sh1        <= {sh1[FRAME_BITS-2:0], 1'b0};
                bit_cnt    <= bit_cnt + 1'b1;
                ADC_sdata0 <= sh0[FRAME_BITS-2];
                ADC_sdata1 <= sh1[FRAME_BITS-2];
            end else if (do_finish || do_abort) begin
                ADC_sdata0 <= 1'b0;
                ADC_sdata1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ad1_adc_responder.sv
// tb_ad1_adc_responder: randomized, self-checking bench for ad1_adc_responder.
// Acts as the capture master (csn/sclk), sampling each data bit just before
// the sclk falling edge that retires it. Expected frame words come from a
// small model: word = {zeros, sample}, sample = stream data when valid,
// otherwise the last accepted pair. Define AD1_RAMP_EN to exercise the ramp.
module tb_ad1_adc_responder;

    logic        clk;
    logic        rst;
    logic [11:0] s_data0;
    logic [11:0] s_data1;
    logic        s_valid;
    logic        s_ready;
    logic        ADC_csn;
    logic        ADC_sclk;
    logic        ADC_sdata0;
    logic        ADC_sdata1;
    logic        frame_done;
    logic        underrun;
    logic        aborted;
`ifdef AD1_RAMP_EN
    logic        ramp_sel;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int ready_total = 0;
    int done_total  = 0;

    logic [11:0] model_held0;
    logic [11:0] model_held1;
    logic        model_underrun;

    ad1_adc_responder #(
        .DATA_W      (12),
        .LEAD_ZEROS  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data0    (s_data0),
        .s_data1    (s_data1),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .ADC_csn    (ADC_csn),
        .ADC_sclk   (ADC_sclk),
        .ADC_sdata0 (ADC_sdata0),
        .ADC_sdata1 (ADC_sdata1),
        .frame_done (frame_done),
        .underrun   (underrun),
        .aborted    (aborted)
`ifdef AD1_RAMP_EN
        ,
        .ramp_sel   (ramp_sel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters observed away from the active edge
    always @(negedge clk) begin
        if (s_ready)    ready_total = ready_total + 1;
        if (frame_done) done_total  = done_total + 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_frame();
        ADC_csn = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic end_frame();
        ADC_csn = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // n sclk pulses; each bit is captured just before its falling edge
    task automatic shift_bits(input int n, output logic [31:0] c0, output logic [31:0] c1);
        c0 = '0;
        c1 = '0;
        for (int i = 0; i < n; i++) begin
            c0 = {c0[30:0], ADC_sdata0};
            c1 = {c1[30:0], ADC_sdata1};
            ADC_sclk = 1'b0;
            repeat (5) @(negedge clk);
            ADC_sclk = 1'b1;
            repeat (5) @(negedge clk);
        end
    endtask

    // model: the pair carried by the next frame, updating the held pair
    task automatic model_frame(input logic v, input logic [11:0] d0, input logic [11:0] d1,
                               output logic [15:0] e0, output logic [15:0] e1);
        if (v) begin
            model_held0 = d0;
            model_held1 = d1;
        end else begin
            model_underrun = 1'b1;
        end
        e0 = {4'h0, model_held0};
        e1 = {4'h0, model_held1};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_held0    = '0;
        model_held1    = '0;
        model_underrun = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready got %b want 0", s_ready); else pass_cnt++;
        chk_cnt++; if ({ADC_sdata0, ADC_sdata1} !== 2'b00) $display("FAIL reset_sdata got %b%b want 00", ADC_sdata0, ADC_sdata1); else pass_cnt++;
        chk_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", underrun); else pass_cnt++;
        chk_cnt++; if (aborted !== 1'b0) $display("FAIL reset_aborted got %b want 0", aborted); else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        logic [31:0] c0, c1;
        logic [15:0] e0, e1;
        int r0, d0;
        s_valid = 1'b1; s_data0 = 12'hA5C; s_data1 = 12'h3F0;
        model_frame(s_valid, s_data0, s_data1, e0, e1);
        r0 = ready_total; d0 = done_total;
        start_frame();
        s_data0 = 12'($urandom); s_data1 = 12'($urandom);
        shift_bits(16, c0, c1);
        end_frame();
        chk_cnt++; if (c0[15:0] !== e0) $display("FAIL basic_ch0 got %h want %h", c0[15:0], e0); else pass_cnt++;
        chk_cnt++; if (c1[15:0] !== e1) $display("FAIL basic_ch1 got %h want %h", c1[15:0], e1); else pass_cnt++;
        chk_cnt++; if (ready_total - r0 !== 1) $display("FAIL basic_ready_pulses got %0d want 1", ready_total - r0); else pass_cnt++;
        chk_cnt++; if (done_total - d0 !== 1) $display("FAIL basic_done_pulses got %0d want 1", done_total - d0); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL basic_underrun got %b want 0", underrun); else pass_cnt++;
    endtask

    task automatic test_underrun();
        logic [31:0] c0, c1;
        logic [15:0] e0, e1;
        int r0, d0;
        s_valid = 1'b0; s_data0 = 12'h123; s_data1 = 12'hFED;
        model_frame(s_valid, s_data0, s_data1, e0, e1);
        r0 = ready_total; d0 = done_total;
        start_frame();
        shift_bits(16, c0, c1);
        end_frame();
        chk_cnt++; if (c0[15:0] !== e0) $display("FAIL underrun_ch0 got %h want %h", c0[15:0], e0); else pass_cnt++;
        chk_cnt++; if (c1[15:0] !== e1) $display("FAIL underrun_ch1 got %h want %h", c1[15:0], e1); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b1) $display("FAIL underrun_flag got %b want 1", underrun); else pass_cnt++;
        chk_cnt++; if (ready_total - r0 !== 0) $display("FAIL underrun_ready_pulses got %0d want 0", ready_total - r0); else pass_cnt++;
        chk_cnt++; if (done_total - d0 !== 1) $display("FAIL underrun_done_pulses got %0d want 1", done_total - d0); else pass_cnt++;
    endtask

    task automatic test_random_frames();
        logic [31:0] c0, c1;
        logic [15:0] e0, e1;
        int r0, d0;
        for (int f = 0; f < 8; f++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data0 = 12'($urandom); s_data1 = 12'($urandom);
            model_frame(s_valid, s_data0, s_data1, e0, e1);
            r0 = ready_total; d0 = done_total;
            start_frame();
            shift_bits(16, c0, c1);
            end_frame();
            chk_cnt++; if (c0[15:0] !== e0) $display("FAIL random_ch0 frame %0d got %h want %h", f, c0[15:0], e0); else pass_cnt++;
            chk_cnt++; if (c1[15:0] !== e1) $display("FAIL random_ch1 frame %0d got %h want %h", f, c1[15:0], e1); else pass_cnt++;
            chk_cnt++; if (ready_total - r0 !== int'(s_valid)) $display("FAIL random_ready frame %0d got %0d want %0d", f, ready_total - r0, s_valid); else pass_cnt++;
            chk_cnt++; if (done_total - d0 !== 1) $display("FAIL random_done frame %0d got %0d want 1", f, done_total - d0); else pass_cnt++;
            chk_cnt++; if (underrun !== model_underrun) $display("FAIL random_underrun frame %0d got %b want %b", f, underrun, model_underrun); else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        logic [31:0] c0, c1;
        logic [15:0] e0, e1;
        int r0, d0;
        s_valid = 1'b1;
        s_data0 = 12'($urandom) | 12'h100;
        s_data1 = 12'($urandom) | 12'h100;
        model_frame(s_valid, s_data0, s_data1, e0, e1);
        d0 = done_total;
        start_frame();
        shift_bits(7, c0, c1);
        chk_cnt++; if (c0[6:0] !== e0[15:9]) $display("FAIL abort_partial_ch0 got %h want %h", c0[6:0], e0[15:9]); else pass_cnt++;
        ADC_csn = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++; if ({ADC_sdata0, ADC_sdata1} !== 2'b11) $display("FAIL abort_sdata_early got %b%b want 11", ADC_sdata0, ADC_sdata1); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({ADC_sdata0, ADC_sdata1} !== 2'b00) $display("FAIL abort_sdata_zero got %b%b want 00", ADC_sdata0, ADC_sdata1); else pass_cnt++;
        repeat (4) @(negedge clk);
        chk_cnt++; if (aborted !== 1'b1) $display("FAIL abort_flag got %b want 1", aborted); else pass_cnt++;
        chk_cnt++; if (done_total - d0 !== 0) $display("FAIL abort_done_pulses got %0d want 0", done_total - d0); else pass_cnt++;
        // next frame carries the next stream pair
        s_data0 = 12'($urandom); s_data1 = 12'($urandom);
        model_frame(s_valid, s_data0, s_data1, e0, e1);
        r0 = ready_total;
        start_frame();
        shift_bits(16, c0, c1);
        end_frame();
        chk_cnt++; if (c0[15:0] !== e0) $display("FAIL abort_next_ch0 got %h want %h", c0[15:0], e0); else pass_cnt++;
        chk_cnt++; if (c1[15:0] !== e1) $display("FAIL abort_next_ch1 got %h want %h", c1[15:0], e1); else pass_cnt++;
        chk_cnt++; if (ready_total - r0 !== 1) $display("FAIL abort_next_ready got %0d want 1", ready_total - r0); else pass_cnt++;
    endtask

    task automatic test_extra_pulses();
        logic [31:0] c0, c1;
        logic [15:0] e0, e1;
        int d0;
        s_valid = 1'b1; s_data0 = 12'($urandom) | 12'h001; s_data1 = 12'($urandom) | 12'h001;
        model_frame(s_valid, s_data0, s_data1, e0, e1);
        d0 = done_total;
        start_frame();
        shift_bits(20, c0, c1);
        chk_cnt++; if (c0[19:4] !== e0) $display("FAIL extra_ch0 got %h want %h", c0[19:4], e0); else pass_cnt++;
        chk_cnt++; if (c1[19:4] !== e1) $display("FAIL extra_ch1 got %h want %h", c1[19:4], e1); else pass_cnt++;
        chk_cnt++; if ({c0[3:0], c1[3:0], ADC_sdata0, ADC_sdata1} !== 10'h0) $display("FAIL extra_tail got %h %h want 0", c0[3:0], c1[3:0]); else pass_cnt++;
        end_frame();
        chk_cnt++; if (done_total - d0 !== 1) $display("FAIL extra_done_pulses got %0d want 1", done_total - d0); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] c0, c1;
        logic [15:0] e0, e1;
        int d0;
        s_valid = 1'b1; s_data0 = 12'hFFF; s_data1 = 12'hFFF;
        start_frame();
        shift_bits(6, c0, c1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_held0 = '0; model_held1 = '0; model_underrun = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if ({s_ready, ADC_sdata0, ADC_sdata1, frame_done} !== 4'b0) $display("FAIL midrst_outputs got %b%b%b%b want 0000", s_ready, ADC_sdata0, ADC_sdata1, frame_done); else pass_cnt++;
        chk_cnt++; if ({underrun, aborted} !== 2'b00) $display("FAIL midrst_sticky got %b%b want 00", underrun, aborted); else pass_cnt++;
        end_frame();
        s_data0 = 12'($urandom); s_data1 = 12'($urandom);
        model_frame(s_valid, s_data0, s_data1, e0, e1);
        d0 = done_total;
        start_frame();
        shift_bits(16, c0, c1);
        end_frame();
        chk_cnt++; if (c0[15:0] !== e0) $display("FAIL midrst_ch0 got %h want %h", c0[15:0], e0); else pass_cnt++;
        chk_cnt++; if (c1[15:0] !== e1) $display("FAIL midrst_ch1 got %h want %h", c1[15:0], e1); else pass_cnt++;
        chk_cnt++; if (aborted !== 1'b0) $display("FAIL midrst_aborted got %b want 0", aborted); else pass_cnt++;
        chk_cnt++; if (done_total - d0 !== 1) $display("FAIL midrst_done got %0d want 1", done_total - d0); else pass_cnt++;
    endtask

`ifdef AD1_RAMP_EN
    task automatic test_ramp();
        logic [31:0] c0, c1;
        logic [11:0] rv;
        int r0, d0;
        do_reset();
        ramp_sel = 1'b1;
        s_valid  = 1'b0;
        r0 = ready_total;
        d0 = done_total;
        for (int f = 0; f <= 4096; f++) begin
            rv = 12'(f);
            s_data0 = 12'($urandom); s_data1 = 12'($urandom);
            if (f < 4 || f >= 4095) begin
                start_frame();
                shift_bits(16, c0, c1);
                end_frame();
                chk_cnt++; if (c0[15:0] !== {4'h0, rv}) $display("FAIL ramp_ch0 frame %0d got %h want %h", f, c0[15:0], {4'h0, rv}); else pass_cnt++;
                chk_cnt++; if (c1[15:0] !== {4'h0, ~rv}) $display("FAIL ramp_ch1 frame %0d got %h want %h", f, c1[15:0], {4'h0, ~rv}); else pass_cnt++;
            end else begin
                ADC_csn = 1'b0;
                repeat (5) @(negedge clk);
                ADC_csn = 1'b1;
                repeat (5) @(negedge clk);
            end
        end
        chk_cnt++; if (ready_total - r0 !== 0) $display("FAIL ramp_ready got %0d want 0", ready_total - r0); else pass_cnt++;
        chk_cnt++; if (underrun !== 1'b0) $display("FAIL ramp_underrun got %b want 0", underrun); else pass_cnt++;
        chk_cnt++; if (done_total - d0 !== 6) $display("FAIL ramp_done got %0d want 6", done_total - d0); else pass_cnt++;
        ramp_sel = 1'b0;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        ADC_csn  = 1'b1;
        ADC_sclk = 1'b1;
        s_valid  = 1'b0;
        s_data0  = '0;
        s_data1  = '0;
`ifdef AD1_RAMP_EN
        ramp_sel = 1'b0;
`endif
        repeat (4) @(negedge clk);
        test_reset();
        test_basic_frame();
        test_underrun();
        test_random_frames();
        test_abort();
        test_extra_pulses();
        test_reset_midframe();
`ifdef AD1_RAMP_EN
        test_ramp();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
